// File: rtl/alu_wb_stage.sv
// alu_wb_stage: writeback stage behind the ALU.
// Results are buffered in a 2-entry FIFO and retired in order, at most one per cycle.
// A retiring result drives the register-file write port.
// The head entry is also exposed as a forwarding tap.
// A retiring branch raises a one-cycle PC redirect and discards the younger, wrong-path entry.
// in_req bit layout, MSB first: {fur_sig.valid, pc_branch, wb_wr, reg_dst[REG_AW-1:0], dst[DATA_W-1:0]}.
module alu_wb_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_W+REG_AW+2:0]   in_req,
   output logic                       in_ready,
   input  logic                       rf_stall,
   output logic                       rf_we,
   output logic [REG_AW-1:0]          rf_waddr,
   output logic [DATA_W-1:0]          rf_wdata,
   output logic                       fwd_valid,
   output logic [REG_AW-1:0]          fwd_reg,
   output logic [DATA_W-1:0]          fwd_data,
   output logic                       pc_redirect_valid,
   output logic [DATA_W-1:0]          pc_redirect_target,
   output logic [CNT_W-1:0]           retired_cnt
);

   typedef struct packed {
      logic valid;
   } fur_sig_t;

   typedef struct packed {
      fur_sig_t            fur_sig;
      logic                pc_branch;
      logic                wb_wr;
      logic [REG_AW-1:0]   reg_dst;
      logic [DATA_W-1:0]   dst;
   } alu_to_wb_req_t;

   alu_to_wb_req_t      w_req;
   alu_to_wb_req_t      w_head;
   alu_to_wb_req_t      r_mem [2];
   logic                r_head;
   logic                r_tail;
   logic [1:0]          r_count;
   logic [CNT_W-1:0]    r_retired_cnt;

   logic                w_nonempty;
   logic                w_retire;
   logic                w_redirect;
   logic                w_writes_reg;
   logic                w_push;

   assign w_req        = alu_to_wb_req_t'(in_req);
   assign w_head       = r_mem[r_head];
   assign w_nonempty   = (r_count != 2'd0);
   assign w_retire     = w_nonempty && !rf_stall;
   assign w_redirect   = w_retire && w_head.pc_branch;
   assign w_writes_reg = w_nonempty && w_head.wb_wr && (w_head.reg_dst != {REG_AW{1'b0}});
   // Gating with rst_n keeps every output low for the whole time reset is held.
   assign in_ready     = rst_n && (r_count != 2'd2) && !w_redirect;
   assign w_push       = w_req.fur_sig.valid && in_ready;

   // Head-entry outputs; every field reads as zero while the buffer is empty.
   always_comb begin
      rf_we              = 1'b0;
      rf_waddr           = {REG_AW{1'b0}};
      rf_wdata           = {DATA_W{1'b0}};
      fwd_valid          = 1'b0;
      fwd_reg            = {REG_AW{1'b0}};
      fwd_data           = {DATA_W{1'b0}};
      pc_redirect_valid  = 1'b0;
      pc_redirect_target = {DATA_W{1'b0}};
      if (w_nonempty) begin
         rf_we              = w_retire && w_writes_reg;
         rf_waddr           = w_head.reg_dst;
         rf_wdata           = w_head.dst;
         fwd_valid          = w_writes_reg;
         fwd_reg            = w_head.reg_dst;
         fwd_data           = w_head.dst;
         pc_redirect_valid  = w_redirect;
         pc_redirect_target = w_head.dst;
      end else begin
         rf_we              = 1'b0;
      end
   end

   // Entry storage: a push writes the tail slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_tail] <= w_req;
      end else begin
         r_mem <= r_mem;
      end
   end

   // Pointers and occupancy; a redirect empties the buffer (no push can coincide).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= 1'b0;
         r_tail  <= 1'b0;
         r_count <= 2'd0;
      end else if (w_redirect) begin
         r_head  <= 1'b0;
         r_tail  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push) begin
            r_tail <= ~r_tail;
         end
         if (w_retire) begin
            r_head <= ~r_head;
         end
         case ({w_push, w_retire})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Retired-instruction counter; it wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retired_cnt <= {CNT_W{1'b0}};
      end else if (w_retire) begin
         r_retired_cnt <= r_retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_retired_cnt <= r_retired_cnt;
      end
   end

   assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Testbench for alu_wb_stage.
// Directed scenarios are followed by randomized traffic.
// Every cycle is compared against a queue-based reference model.
module tb_alu_wb_stage;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;

   logic                      clk;
   logic                      rst_n;
   logic [DATA_W+REG_AW+2:0]  in_req;
   logic                      in_ready;
   logic                      rf_stall;
   logic                      rf_we;
   logic [REG_AW-1:0]         rf_waddr;
   logic [DATA_W-1:0]         rf_wdata;
   logic                      fwd_valid;
   logic [REG_AW-1:0]         fwd_reg;
   logic [DATA_W-1:0]         fwd_data;
   logic                      pc_redirect_valid;
   logic [DATA_W-1:0]         pc_redirect_target;
   logic [CNT_W-1:0]          retired_cnt;

   alu_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .in_req             (in_req),
      .in_ready           (in_ready),
      .rf_stall           (rf_stall),
      .rf_we              (rf_we),
      .rf_waddr           (rf_waddr),
      .rf_wdata           (rf_wdata),
      .fwd_valid          (fwd_valid),
      .fwd_reg            (fwd_reg),
      .fwd_data           (fwd_data),
      .pc_redirect_valid  (pc_redirect_valid),
      .pc_redirect_target (pc_redirect_target),
      .retired_cnt        (retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        br;
      logic        wr;
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   ent_t        model_q [$];
   int unsigned model_cnt;
   int          n_checks;
   int          n_errors;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle: drive inputs, compare against the model, then advance the model.
   task automatic step(input logic v, input logic br, input logic wr, input logic [4:0] rd,
                       input logic [31:0] d, input logic st, output logic acc);
      int   n;
      ent_t h;
      logic e_ret, e_red, e_rdy, e_fv;
      @(posedge clk);
      #1;
      in_req   = {v, br, wr, rd, d};
      rf_stall = st;
      @(negedge clk);
      n = model_q.size();
      if (n > 0) begin
         h = model_q[0];
      end else begin
         h.br = 1'b0; h.wr = 1'b0; h.rd = 5'd0; h.d = 32'd0;
      end
      e_ret = (n > 0) && !st;
      e_red = e_ret && h.br;
      e_rdy = (n < 2) && !e_red;
      e_fv  = (n > 0) && h.wr && (h.rd != 5'd0);
      check_eq("in_ready",    64'(in_ready),           64'(e_rdy));
      check_eq("rf_we",       64'(rf_we),              64'(e_ret && e_fv));
      check_eq("rf_waddr",    64'(rf_waddr),           64'(h.rd));
      check_eq("rf_wdata",    64'(rf_wdata),           64'(h.d));
      check_eq("fwd_valid",   64'(fwd_valid),          64'(e_fv));
      check_eq("fwd_reg",     64'(fwd_reg),            64'(h.rd));
      check_eq("fwd_data",    64'(fwd_data),           64'(h.d));
      check_eq("redir_valid", 64'(pc_redirect_valid),  64'(e_red));
      check_eq("redir_tgt",   64'(pc_redirect_target), 64'(h.d));
      check_eq("retired_cnt", 64'(retired_cnt),        64'(model_cnt % 16));
      acc = v && e_rdy;
      if (e_ret) begin
         void'(model_q.pop_front());
         model_cnt++;
         if (e_red) model_q.delete();
      end
      if (acc) begin
         h.br = br; h.wr = wr; h.rd = rd; h.d = d;
         model_q.push_back(h);
      end
   endtask

   task automatic idle(input logic st);
      logic a;
      step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, st, a);
   endtask

   initial begin
      logic acc;
      int   idx;
      ent_t bp [3];
      n_checks  = 0;
      n_errors  = 0;
      model_cnt = 0;
      rst_n     = 1'b0;
      in_req    = '0;
      rf_stall  = 1'b0;
      #2;
      check_eq("rst_ready", 64'(in_ready), 64'd0);
      check_eq("rst_cnt",   64'(retired_cnt), 64'd0);
      #20;
      rst_n = 1'b1;

      // Single write to r3.
      step(1'b1, 1'b0, 1'b1, 5'd3, 32'h1234, 1'b0, acc);
      check_eq("single_acc", 64'(acc), 64'd1);
      idle(1'b0);
      idle(1'b0);
      check_eq("single_cnt", 64'(retired_cnt), 64'd1);

      // Back-pressure: three requests under stall, then release.
      bp[0].br = 1'b0; bp[0].wr = 1'b1; bp[0].rd = 5'd7;  bp[0].d = 32'hA1;
      bp[1].br = 1'b0; bp[1].wr = 1'b1; bp[1].rd = 5'd8;  bp[1].d = 32'hA2;
      bp[2].br = 1'b0; bp[2].wr = 1'b1; bp[2].rd = 5'd9;  bp[2].d = 32'hA3;
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         step(1'b1, bp[idx].br, bp[idx].wr, bp[idx].rd, bp[idx].d, 1'b1, acc);
         if (acc && idx < 2) idx++;
      end
      check_eq("bp_full_rdy", 64'(in_ready), 64'd0);
      for (int c = 0; c < 6 && idx < 3; c++) begin
         step(1'b1, bp[idx].br, bp[idx].wr, bp[idx].rd, bp[idx].d, 1'b0, acc);
         if (acc) idx++;
      end
      for (int c = 0; c < 4; c++) idle(1'b0);
      check_eq("bp_cnt", 64'(retired_cnt), 64'd4);

      // Write to register 0 is suppressed but still retires.
      step(1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b0, acc);
      idle(1'b0);
      idle(1'b0);
      check_eq("r0_cnt", 64'(retired_cnt), 64'd5);

      // Branch flush: branch-and-link at head, younger ALU write behind it.
      step(1'b1, 1'b1, 1'b1, 5'd1, 32'h80, 1'b1, acc);
      step(1'b1, 1'b0, 1'b1, 5'd5, 32'h55, 1'b1, acc);
      step(1'b1, 1'b0, 1'b1, 5'd6, 32'h66, 1'b0, acc);
      check_eq("flush_acc", 64'(acc), 64'd0);
      idle(1'b0);
      check_eq("flush_fwd", 64'(fwd_valid), 64'd0);
      check_eq("flush_cnt", 64'(retired_cnt), 64'd6);

      // Asynchronous reset while stalled and full.
      step(1'b1, 1'b0, 1'b1, 5'd10, 32'hB0, 1'b1, acc);
      step(1'b1, 1'b0, 1'b1, 5'd11, 32'hB1, 1'b1, acc);
      idle(1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_rdy",   64'(in_ready), 64'd0);
      check_eq("arst_fwd",   64'(fwd_valid), 64'd0);
      check_eq("arst_freg",  64'(fwd_reg), 64'd0);
      check_eq("arst_fdata", 64'(fwd_data), 64'd0);
      check_eq("arst_rdir",  64'(pc_redirect_target), 64'd0);
      check_eq("arst_cnt",   64'(retired_cnt), 64'd0);
      model_q.delete();
      model_cnt = 0;
      @(negedge clk);
      #2;
      rst_n = 1'b1;

      // Fresh push plus 16 more writes: counter wraps to 1.
      for (int c = 0; c < 17; c++) begin
         step(1'b1, 1'b0, 1'b1, 5'(c + 1), 32'(c * 3), 1'b0, acc);
      end
      idle(1'b0);
      idle(1'b0);
      check_eq("cnt_wrap", 64'(retired_cnt), 64'd1);

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'($urandom),
              ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
              $urandom_range(0, 3) == 0, acc);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
